// File: rtl/axis_multi_fifo.sv
// axis_multi_fifo
//
// Multi-channel AXI4-Stream FIFO. Each of CHANNELS input streams is buffered
// in a private FIFO. A frame-aware round-robin arbiter drains the FIFOs onto
// a single output stream. Each output beat carries its source channel on tdest.
//
// Optional build macro: AXIS_MULTI_FIFO_STATUS_EN
//   When defined, this adds per-channel status_depth (current count) and
//   status_full outputs. When undefined, neither port exists.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_axis_*        CHANNELS input streams; channel i occupies slice i
//   m_axis_*        merged output stream; tdest = source channel index
//   status_depth    (macro only) per-channel FIFO count
//   status_full     (macro only) per-channel count == DEPTH
//
// Arbiter states:
//   state  | meaning
//   IDLE   | scan from rr pointer for a non-empty channel, load its first beat
//   LOCKED | read only the granted channel until its tlast beat is loaded

module axis_multi_fifo #(
    parameter int CHANNELS    = 4,
    parameter int DEPTH       = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int DEST_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [CHANNELS-1:0]            s_axis_tvalid,
    output logic [CHANNELS-1:0]            s_axis_tready,
    input  logic [CHANNELS-1:0]            s_axis_tlast,
    input  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
`ifdef AXIS_MULTI_FIFO_STATUS_EN
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0] status_depth,
    output logic [CHANNELS-1:0]            status_full,
`endif
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [DEST_WIDTH-1:0]          m_axis_tdest,
    output logic [USER_WIDTH-1:0]          m_axis_tuser
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [DEST_WIDTH-1:0] rr_q, rr_d;
    logic [DEST_WIDTH-1:0] grant_q, grant_d;

    logic [EW-1:0] mem_q [CHANNELS][DEPTH];
    logic [PW-1:0] wr_ptr_q [CHANNELS];
    logic [PW-1:0] rd_ptr_q [CHANNELS];
    logic [CW-1:0] count_q  [CHANNELS];

    logic [DATA_WIDTH-1:0] m_data_q;
    logic [KEEP_WIDTH-1:0] m_keep_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic [DEST_WIDTH-1:0] m_dest_q;
    logic [USER_WIDTH-1:0] m_user_q;

    logic [CHANNELS-1:0]   wr_en;
    logic [CHANNELS-1:0]   rd_en;
    logic [DEST_WIDTH-1:0] pick;
    logic                  found;
    int                    scan_t;
    logic [DEST_WIDTH-1:0] scan_idx;
    logic [DEST_WIDTH-1:0] sel;
    logic [DEST_WIDTH-1:0] sel_next;
    logic                  sel_avail;
    logic                  load;
    logic [EW-1:0]         head;

    // Ready depends only on the registered count, so a full FIFO that is being
    // drained this cycle still reports not-ready.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign s_axis_tready[g] = (count_q[g] != CW'(DEPTH));
        assign wr_en[g]         = s_axis_tvalid[g] & s_axis_tready[g];
        assign rd_en[g]         = load & (sel == DEST_WIDTH'(g));
`ifdef AXIS_MULTI_FIFO_STATUS_EN
        assign status_depth[g*CW +: CW] = count_q[g];
        assign status_full[g]           = (count_q[g] == CW'(DEPTH));
`endif
    end

    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_t   = 0;
        scan_idx = '0;
        // Scan upward from rr with wrap; the first non-empty channel wins.
        for (int k = 0; k < CHANNELS; k++) begin
            scan_t = int'(rr_q) + k;
            if (scan_t >= CHANNELS) scan_t = scan_t - CHANNELS;
            scan_idx = DEST_WIDTH'(scan_t);
            if (!found && count_q[scan_idx] != '0) begin
                pick  = scan_idx;
                found = 1'b1;
            end
        end

        if (state_q == LOCKED) begin
            sel       = grant_q;
            sel_avail = (count_q[grant_q] != '0);
        end else begin
            sel       = pick;
            sel_avail = found;
        end

        load     = (!m_valid_q || m_axis_tready) && sel_avail;
        head     = mem_q[sel][rd_ptr_q[sel]];
        sel_next = (int'(sel) == CHANNELS - 1) ? '0 : sel + 1'b1;

        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (load) begin
            grant_d = sel;
            // A beat with tlast ends the frame, including single-beat frames
            // that are loaded directly from IDLE.
            if (head[USER_WIDTH]) begin
                state_d = IDLE;
                rr_d    = sel_next;
            end else begin
                state_d = LOCKED;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH],
                                          s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
                                          s_axis_tlast[i],
                                          s_axis_tuser[i*USER_WIDTH +: USER_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_dest_q  <= '0;
            m_user_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (rd_en[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                if (wr_en[i] && !rd_en[i]) begin
                    count_q[i] <= count_q[i] + 1'b1;
                end else if (!wr_en[i] && rd_en[i]) begin
                    count_q[i] <= count_q[i] - 1'b1;
                end
            end
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= head[EW-1 -: DATA_WIDTH];
                m_keep_q  <= (KEEP_ENABLE != 0) ? head[USER_WIDTH+1 +: KEEP_WIDTH] : '1;
                m_last_q  <= head[USER_WIDTH];
                m_dest_q  <= sel;
                m_user_q  <= (USER_ENABLE != 0) ? head[USER_WIDTH-1:0] : '0;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdest  = m_dest_q;
    assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_axis_multi_fifo.sv
module tb_axis_multi_fifo;

    localparam int CH = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH*8-1:0] s_tdata = '0;
    logic [CH-1:0] s_tkeep = '1;
    logic [CH-1:0] s_tvalid = '0;
    logic [CH-1:0] s_tready;
    logic [CH-1:0] s_tlast = '0;
    logic [CH-1:0] s_tuser = '0;
    logic [7:0]    m_tdata;
    logic [0:0]    m_tkeep;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [1:0]    m_tdest;
    logic [0:0]    m_tuser;
`ifdef AXIS_MULTI_FIFO_STATUS_EN
    logic [CH*5-1:0] status_depth;
    logic [CH-1:0]   status_full;
`endif

    axis_multi_fifo dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser),
`ifdef AXIS_MULTI_FIFO_STATUS_EN
        .status_depth(status_depth),
        .status_full(status_full),
`endif
        .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .m_axis_tdest(m_tdest),
        .m_axis_tuser(m_tuser)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    // expected beat: {tdest[1:0], tlast, tuser, tdata[7:0]}
    logic [11:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor: runs at the negative edge, before the handshake edge.
    task automatic mon();
        logic [11:0] got;
        logic [11:0] exp;
        if (!rst && m_tvalid && m_tready) begin
            got = {m_tdest, m_tlast, m_tuser, m_tdata};
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra got=%h exp=none", got);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                total++;
                assert (got === exp) else begin
                    bad++;
                    $error("FAIL sb_beat got=%h exp=%h", got, exp);
                end
            end
            total++;
            assert (m_tkeep === 1'b1) else begin
                bad++;
                $error("FAIL tkeep got=%h exp=1", m_tkeep);
            end
        end
    endtask

    // Advance one cycle; inputs change and checks happen 1 time unit after posedge.
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic l, input bit to_sb);
        int n;
        s_tdata[ch*8 +: 8] = d;
        s_tlast[ch]  = l;
        s_tuser[ch]  = d[0];
        s_tvalid[ch] = 1'b1;
        n = 0;
        while (!s_tready[ch] && n < 60) begin
            tick();
            n++;
        end
        total++;
        assert (n < 60) else begin
            bad++;
            $error("FAIL push_timeout ch=%0d got=stuck exp=ready", ch);
        end
        if (to_sb) sb.push_back({2'(ch), l, d[0], d});
        tick();
        s_tvalid[ch] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(s_tready), 32'hF);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tdest", 32'(m_tdest), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        rst = 1'b0;
        tick();

        // Single channel, 1-cycle latency
        m_tready = 1'b1;
        push(1, 8'h11, 1'b0, 1'b1);
        chk("lat_pre", 32'(m_tvalid), 32'd0);
        tick();
        chk("lat_post_valid", 32'(m_tvalid), 32'd1);
        chk("lat_post_data", 32'(m_tdata), 32'h11);
        chk("lat_post_dest", 32'(m_tdest), 32'd1);
        push(1, 8'h22, 1'b0, 1'b1);
        push(1, 8'h33, 1'b1, 1'b1);
        drain();

        // Round-robin: ch0, ch2, ch3 preloaded, then a second ch0 frame
        m_tready = 1'b0;
        push(0, 8'hA0, 1'b0, 1'b1);
        push(0, 8'hA1, 1'b1, 1'b1);
        push(2, 8'hC0, 1'b0, 1'b1);
        push(2, 8'hC1, 1'b1, 1'b1);
        push(3, 8'hD0, 1'b0, 1'b1);
        push(3, 8'hD1, 1'b1, 1'b1);
        push(0, 8'hA2, 1'b0, 1'b1);
        push(0, 8'hA3, 1'b1, 1'b1);
        m_tready = 1'b1;
        drain();

        // Frame lock: ch0 A, ch1 frame queued, ch0 stalls, then B
        push(0, 8'h5A, 1'b0, 1'b1);
        push(1, 8'h61, 1'b0, 1'b0);
        push(1, 8'h62, 1'b1, 1'b0);
        repeat (5) tick();
        chk("lock_bubble", 32'(m_tvalid), 32'd0);
        push(0, 8'h5B, 1'b1, 1'b1);
        sb.push_back({2'd1, 1'b0, 1'b1, 8'h61});
        sb.push_back({2'd1, 1'b1, 1'b0, 8'h62});
        drain();

        // Full / backpressure on ch2
        m_tready = 1'b0;
        acc = 0;
        s_tvalid[2] = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (acc < 20) begin
                s_tdata[2*8 +: 8] = 8'(8'h40 + acc);
                s_tlast[2] = 1'b1;
                s_tuser[2] = s_tdata[2*8];
                if (s_tready[2]) begin
                    sb.push_back({2'd2, 1'b1, s_tdata[2*8], s_tdata[2*8 +: 8]});
                    acc++;
                end
            end
            tick();
        end
        s_tvalid[2] = 1'b0;
        chk("full_accepted", 32'(acc), 32'd17);
        chk("full_tready", 32'(s_tready[2]), 32'd0);
`ifdef AXIS_MULTI_FIFO_STATUS_EN
        chk("full_depth", 32'(status_depth[2*5 +: 5]), 32'd16);
        chk("full_flag", 32'(status_full[2]), 32'd1);
`endif
        m_tready = 1'b1;
        drain();

        // Simultaneous read/write at full on ch0
        m_tready = 1'b0;
        acc = 0;
        s_tvalid[0] = 1'b1;
        s_tlast[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            s_tdata[0 +: 8] = 8'(8'h80 + acc);
            s_tuser[0] = s_tdata[0];
            if (s_tready[0]) begin
                sb.push_back({2'd0, 1'b1, s_tdata[0], s_tdata[0 +: 8]});
                acc++;
            end
            tick();
            chk("rw_occupancy_le", 32'(sb.size() <= DEPTH + 1), 32'd1);
`ifdef AXIS_MULTI_FIFO_STATUS_EN
            chk("rw_depth_le", 32'(status_depth[4:0] <= 5'd16), 32'd1);
`endif
            if (c >= 20) m_tready = ~m_tready;
        end
        s_tvalid[0] = 1'b0;
        m_tready = 1'b1;
        drain();

        // Reset in the middle of a ch3 frame
        m_tready = 1'b0;
        push(3, 8'hE0, 1'b0, 1'b0);
        push(3, 8'hE1, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_tready", 32'(s_tready), 32'hF);
        m_tready = 1'b1;
        push(1, 8'h77, 1'b0, 1'b1);
        push(1, 8'h78, 1'b1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_multi_fifo.md
Name: axis_multi_fifo

Overview:
Multi-channel AXI4-Stream FIFO. CHANNELS independent input streams are each buffered in a private FIFO. A frame-aware round-robin arbiter drains the FIFOs onto one output stream and tags each beat with its source channel on tdest. It sits ahead of shared downstream consumers (e.g. a host DMA/UART bridge) where several producers feed one sink.

Parameters:
CHANNELS, 4, number of input channels (1..16)
DEPTH, 16, per-channel FIFO depth in beats; power of 2, >= 2
DATA_WIDTH, 8, tdata width per channel
KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0 the output tkeep is all-ones
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width per channel
USER_ENABLE, 1, propagate tuser; when 0 the output tuser is 0
USER_WIDTH, 1, tuser width per channel
DEST_WIDTH, max(1,clog2(CHANNELS)), width of the output tdest (channel index)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  CHANNELS*DATA_WIDTH  channel i data at slice i
s_axis_tkeep  in  CHANNELS*KEEP_WIDTH  per-channel keep
s_axis_tvalid  in  CHANNELS  per-channel valid
s_axis_tready  out  CHANNELS  per-channel ready
s_axis_tlast  in  CHANNELS  per-channel last
s_axis_tuser  in  CHANNELS*USER_WIDTH  per-channel user
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tkeep  out  KEEP_WIDTH  output keep
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last
m_axis_tdest  out  DEST_WIDTH  source channel index of the current beat
m_axis_tuser  out  USER_WIDTH  output user

Behaviour:
- Reset: all FIFO pointers and counts = 0; s_axis_tready = all-ones; m_axis_tvalid = 0; m_axis_tdata/tkeep/tlast/tdest/tuser = 0; arbiter state IDLE; rr pointer = 0. Reset asserted mid-frame discards all buffered data and any partial frames.
- Per-channel FIFO: entry = {tdata, tkeep, tlast, tuser}. Count width clog2(DEPTH)+1. s_axis_tready[i] = (count_i != DEPTH), registered from count only, with no combinational path from m_axis_tready. A full FIFO draining in the same cycle still shows ready=0 for that cycle. Write happens when tvalid[i] & tready[i]. A simultaneous write and read on the same channel leaves the count unchanged. Pointers wrap modulo DEPTH.
- Output register: one stage. It loads when (!m_axis_tvalid | m_axis_tready) and the granted FIFO is non-empty. m_axis_tvalid stays high until the beat is accepted. Data is held stable while tvalid=1 and tready=0.
- Latency: a beat accepted on s_axis at edge k on an idle block appears with m_axis_tvalid=1 after edge k+1. Throughput is 1 beat/cycle sustained.
- Arbiter FSM:
  - IDLE: scan channels starting at rr pointer and moving upward with wrap. Grant the first non-empty channel and go to LOCKED in the same cycle that channel's first beat is loaded.
  - LOCKED: read only the granted channel until a beat with tlast=1 is loaded into the output register. Then set rr = grant+1 (mod CHANNELS) and return to IDLE.
  - A granted FIFO running empty mid-frame keeps LOCKED; the output bubbles (tvalid=0) and no other channel may interleave.
  - Back-to-back frames: the next grant may load in the cycle after the tlast beat loads, so there is at most 1 bubble cycle between frames of different channels.
- CHANNELS=1: the arbiter degenerates and m_axis_tdest = 0.
- tdest = grant index, registered alongside the data.

Optional Feature:
AXIS_MULTI_FIFO_STATUS_EN:
- Defined: adds output port status_depth (CHANNELS*(clog2(DEPTH)+1)), the per-channel current count, registered and 0 at reset. Also adds output port status_full (CHANNELS), equal to count_i==DEPTH.
- Undefined: neither port exists and no status logic is generated.

Test Plan:
- Single channel: ch1 sends 3-beat frame 0x11,0x22,0x33(last), m_axis_tready=1 -> output after 1-cycle latency: 0x11,0x22,0x33, tdest=1, tlast only on 0x33.
- Round-robin: ch0, ch2, ch3 each preload one 2-beat frame, then ready=1 -> frames emerge in order ch0, ch2, ch3 with tdest 0,2,3. A ch0 frame arriving next is served after ch3.
- Frame lock: ch0 sends beat A, stalls 5 cycles, then sends B(last); ch1 has a full frame queued -> output is A, bubbles, B, then ch1. ch1 is never interleaved.
- Full/backpressure: DEPTH=16, m_axis_tready=0, ch2 pushes 20 beats -> tready[2] drops after beat 16 (plus 1 in the output reg, 17 accepted total). Release ready -> all 17 emerge in order, no loss or duplication.
- Simultaneous read/write at full: hold ch0 full, then toggle ready each cycle while pushing -> count never exceeds DEPTH and data order is preserved (with status_depth checked when the macro is defined).
- Reset mid-frame: assert rst for 1 cycle during a ch3 frame -> m_axis_tvalid=0 and all tready=1 next cycle; the first new frame output is clean with tdest correct.
